// File: rtl/sipo_receiver.sv
// rtl/sipo_receiver.sv - serial-in parallel-out receiver, MSB first, done/ack handshake
//
// Collects WIDTH bits, one per bitEn strobe, MSB first, and presents the
// assembled word on dataOut with done held until ack.
//
// Optional build macro: SIPO_PARITY_CHECK_EN
//   defined   - one extra even-parity bit follows the data bits; parityErr
//               reports the XOR of all data bits and the parity bit
//   undefined - exactly WIDTH bits per word; parityErr tied to 0
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a new word (sampled in IDLE and FULL)
//   bitEn      bit strobe; serIn valid this cycle
//   serIn      serial data bit, MSB first
//   ack        consumer has taken dataOut (sampled in FULL)
//   dataOut    last completed word (registered)
//   done       word available, held until ack
//   busy       high while collecting bits
//   parityErr  parity check result (0 when parity checking is not built)

module sipo_receiver #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bitEn,
    input  logic             serIn,
    input  logic             ack,
    output logic [WIDTH-1:0] dataOut,
    output logic             done,
    output logic             busy,
    output logic             parityErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             clear;
    logic             shift;
    logic             load;
    logic             data_phase;
    logic             final_sample;
    logic [WIDTH-1:0] word;

`ifdef SIPO_PARITY_CHECK_EN
    // The sample after the last data bit is the parity bit; it completes the
    // word but is not shifted in.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
    assign data_phase = (cnt != LAST_CNT);
    assign word       = shreg;
`else
    // The last data bit completes the word, so it is merged in on the fly.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    assign data_phase = 1'b1;
    assign word       = {shreg[WIDTH-2:0], serIn};
`endif

    assign final_sample = (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        shift      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear      = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (bitEn) begin
                    shift = data_phase;
                    if (final_sample) begin
                        load       = 1'b1;
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (ack) begin
                    if (start) begin
                        clear      = 1'b1;
                        state_next = COLLECT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == COLLECT);
    assign done = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            cnt     <= '0;
            dataOut <= '0;
        end else begin
            if (clear) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (shift) begin
                shreg <= {shreg[WIDTH-2:0], serIn};
                cnt   <= cnt + CNT_W'(1);
            end
            if (load) begin
                dataOut <= word;
            end
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parityErr <= 1'b0;
        end else if (load) begin
            parityErr <= (^shreg) ^ serIn;
        end else if (state == FULL && ack) begin
            parityErr <= 1'b0;
        end
    end
`else
    assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_receiver.sv
// tb/tb_sipo_receiver.sv - self-checking bench for sipo_receiver
module tb_sipo_receiver;

    localparam int WIDTH = 16;
`ifdef SIPO_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             bitEn = 1'b0;
    logic             serIn = 1'b0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] dataOut;
    logic             done;
    logic             busy;
    logic             parityErr;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_on   = 1'b0;

    sipo_receiver #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .bitEn(bitEn), .serIn(serIn),
        .ack(ack), .dataOut(dataOut), .done(done), .busy(busy),
        .parityErr(parityErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a word is a list of received bits; it is "waiting",
    // "gathering" or "holding" a finished word.
    localparam int WAITING = 0, GATHERING = 1, HOLDING = 2;
    int          m_mode;
    int          m_nbits;
    logic [31:0] m_acc;
    logic [31:0] m_data;
    logic        m_perr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = WAITING; m_nbits = 0; m_acc = 0; m_data = 0; m_perr = 0;
        end else begin
            case (m_mode)
                WAITING: if (start) begin m_mode = GATHERING; m_nbits = 0; m_acc = 0; end
                GATHERING: if (bitEn) begin
                    if (m_nbits < WIDTH) begin
                        m_acc = m_acc * 2 + serIn;
                        m_nbits++;
                        if (!PAR && m_nbits == WIDTH) begin
                            m_data = m_acc; m_mode = HOLDING;
                        end
                    end else begin
                        m_perr = ($countones(m_acc) + serIn) % 2;
                        m_data = m_acc; m_mode = HOLDING;
                    end
                end
                default: if (ack) begin
                    m_perr = 0;
                    if (start) begin m_mode = GATHERING; m_nbits = 0; m_acc = 0; end
                    else m_mode = WAITING;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            check("mon_dataOut", 32'(dataOut), m_data);
            check("mon_done", 32'(done), 32'(m_mode == HOLDING));
            check("mon_busy", 32'(busy), 32'(m_mode == GATHERING));
            check("mon_parityErr", 32'(parityErr), 32'(m_perr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1; bitEn = 1'b0; ack = 1'b0;
        @(negedge clk); start = 1'b0;
    endtask

    // Shift out bits hi..lo of w MSB first with random gaps of up to maxgap
    // cycles; start_noise drives start high alongside the bits.
    task automatic send_bits(input logic [31:0] w, input int hi, input int lo,
                             input int maxgap, input bit start_noise);
        for (int i = hi; i >= lo; i--) begin
            int g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            bitEn = 1'b0;
            repeat (g) @(negedge clk);
            bitEn = 1'b1; serIn = w[i]; start = start_noise;
            @(negedge clk);
        end
        bitEn = 1'b0; serIn = 1'b0; start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int maxgap, input bit start_noise);
        send_bits(32'(w), 15, 0, maxgap, start_noise);
        if (PAR) send_bits(32'(^w), 0, 0, 0, 1'b0);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 40) begin @(negedge clk); k++; end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        // 1: reset and idle
        cyc(2);
        rst = 1'b0;
        mon_on = 1'b1;
        cyc(5);
        check("idle_dataOut", 32'(dataOut), 32'h0);
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_parityErr", 32'(parityErr), 0);

        // 2: back-to-back bits
        pulse_start();
        check("busy_collect", 32'(busy), 1);
        send_word(16'hA5C3, 0, 1'b0);
        check("a5c3_done_latency", 32'(done), 1);
        check("a5c3_data", 32'(dataOut), 32'hA5C3);
        check("a5c3_busy", 32'(busy), 0);
        check("model_a5c3", m_data, 32'hA5C3);
        @(negedge clk); ack = 1'b1;
        @(negedge clk); ack = 1'b0;
        check("ack_to_idle_done", 32'(done), 0);
        check("ack_keeps_data", 32'(dataOut), 32'hA5C3);

        // 3: gapped bits, start ignored mid-word, extra bits in FULL dropped
        pulse_start();
        send_word(16'h8001, 3, 1'b1);
        wait_done("8001_done");
        for (int i = 0; i < 4; i++) begin
            bitEn = 1'b1; serIn = i[0]; @(negedge clk);
        end
        bitEn = 1'b0;
        check("8001_data", 32'(dataOut), 32'h8001);
        check("8001_still_done", 32'(done), 1);

        // 4: hold in FULL, start without ack ignored, then ack+start
        for (int i = 0; i < 10; i++) begin
            start = i[1];
            @(negedge clk);
            check("full_hold_done", 32'(done), 1);
        end
        ack = 1'b1; start = 1'b1;
        @(negedge clk); ack = 1'b0; start = 1'b0;
        check("restart_busy", 32'(busy), 1);
        check("restart_done", 32'(done), 0);
        send_word(16'h1234, 1, 1'b0);
        wait_done("1234_done");
        check("1234_data", 32'(dataOut), 32'h1234);
        ack = 1'b1; @(negedge clk); ack = 1'b0;

        // 5: reset mid-word
        pulse_start();
        send_bits(32'hFFFF, 15, 9, 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_dataOut", 32'(dataOut), 0);
        check("rst_async_busy", 32'(busy), 0);
        check("rst_async_done", 32'(done), 0);
        @(negedge clk); rst = 1'b0;
        cyc(3);
        check("after_rst_done", 32'(done), 0);
        pulse_start();
        send_word(16'hFFFF, 2, 1'b0);
        wait_done("ffff_done");
        check("ffff_data", 32'(dataOut), 32'hFFFF);
        ack = 1'b1; @(negedge clk); ack = 1'b0;

`ifdef SIPO_PARITY_CHECK_EN
        // 6: parity good then bad
        pulse_start();
        send_bits(32'h0001, 15, 0, 0, 1'b0);
        check("par_wait_busy", 32'(busy), 1);
        send_bits(32'h1, 0, 0, 0, 1'b0);
        check("par_ok_done", 32'(done), 1);
        check("par_ok_data", 32'(dataOut), 32'h0001);
        check("par_ok_err", 32'(parityErr), 0);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        pulse_start();
        send_bits(32'h0001, 15, 0, 0, 1'b0);
        send_bits(32'h0, 0, 0, 0, 1'b0);
        check("par_bad_done", 32'(done), 1);
        check("par_bad_data", 32'(dataOut), 32'h0001);
        check("par_bad_err", 32'(parityErr), 1);
        ack = 1'b1; @(negedge clk); ack = 1'b0;
        check("par_err_cleared", 32'(parityErr), 0);
`endif

        cyc(2);
        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
